// File: rtl/fetch_if2.sv
`timescale 1ns/1ps
// Second fetch stage: issues in-order imem requests for the IF1 PC, tags them, and queues responses for decode.
// Optional build macro FETCH_PERF_CNT_EN adds the fetch_stall_cnt output.
module fetch_if2 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] current_pc_if1,
    output logic [31:0] next_pc_if1,
    output logic        pc_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        if2_valid,
    input  logic        id_ready,
    output logic [31:0] if2_pc,
    output logic [31:0] if2_inst,
    output logic        if2_fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_stall_cnt
`endif
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned DEPTH = 2;

    typedef logic [CNT_W:0]   credit_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            fault;
    } if2_entry_t;

    cnt_t            outstanding_q, outstanding_d;
    cnt_t            buffered_q, buffered_d;
    cnt_t            discard_q, discard_d;
    logic            tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic            oq_wr_q, oq_wr_d, oq_rd_q, oq_rd_d;
    logic [XLEN-1:0] tag_q [DEPTH];
    logic [XLEN-1:0] tag_d [DEPTH];
    if2_entry_t      oq_q [DEPTH];
    if2_entry_t      oq_d [DEPTH];

    logic            accept_c;
    logic            rsp_fire_c;
    logic            rsp_keep_c;
    logic            if2_pop_c;
    credit_t         credits_used_c;

    // Request, PC and decode-facing outputs
    always_comb begin
        if2_valid      = (buffered_q != '0);
        if2_pc         = oq_q[oq_rd_q].pc;
        if2_inst       = oq_q[oq_rd_q].inst;
        if2_fault      = oq_q[oq_rd_q].fault;
        if2_pop_c      = if2_valid && id_ready;
        // A queue slot vacated by this cycle's decode pop is reusable at once, which sustains 1 IPC.
        credits_used_c = credit_t'(outstanding_q) + credit_t'(buffered_q) - credit_t'(if2_pop_c);
        imem_req_valid = (credits_used_c < credit_t'(DEPTH)) && !redirect_valid;
        imem_req_addr  = current_pc_if1;
        accept_c       = imem_req_valid && imem_req_ready;
        pc_en          = accept_c || redirect_valid;
        next_pc_if1    = redirect_valid ? redirect_pc : current_pc_if1 + 32'd4;
        rsp_fire_c     = imem_rsp_valid && (outstanding_q != '0);
        rsp_keep_c     = rsp_fire_c && !redirect_valid && (discard_q == '0);
    end

    // Tag FIFO, discard counter and output queue next state
    always_comb begin
        tag_d         = tag_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;
        discard_d     = discard_q;
        oq_d          = oq_q;
        oq_wr_d       = oq_wr_q;
        oq_rd_d       = oq_rd_q;
        buffered_d    = buffered_q;
        outstanding_d = outstanding_q + cnt_t'(accept_c) - cnt_t'(rsp_fire_c);

        if (accept_c) begin
            tag_d[tag_wr_q] = current_pc_if1;
            tag_wr_d        = ~tag_wr_q;
        end
        if (rsp_fire_c) begin
            tag_rd_d = ~tag_rd_q;
        end

        if (redirect_valid) begin
            // No request is accepted while redirecting, so this is exactly what is still in flight.
            discard_d  = outstanding_q - cnt_t'(rsp_fire_c);
            oq_wr_d    = 1'b0;
            oq_rd_d    = 1'b0;
            buffered_d = '0;
        end else begin
            if (rsp_fire_c && (discard_q != '0)) begin
                discard_d = discard_q - cnt_t'(1);
            end
            if (rsp_keep_c) begin
                oq_d[oq_wr_q] = '{pc: tag_q[tag_rd_q], inst: imem_rsp_data, fault: imem_rsp_err};
                oq_wr_d       = ~oq_wr_q;
            end
            if (if2_pop_c) begin
                oq_rd_d = ~oq_rd_q;
            end
            buffered_d = buffered_q + cnt_t'(rsp_keep_c) - cnt_t'(if2_pop_c);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding_q <= '0;
            buffered_q    <= '0;
            discard_q     <= '0;
            tag_wr_q      <= 1'b0;
            tag_rd_q      <= 1'b0;
            oq_wr_q       <= 1'b0;
            oq_rd_q       <= 1'b0;
            tag_q         <= '{default: '0};
            oq_q          <= '{default: '0};
        end else begin
            outstanding_q <= outstanding_d;
            buffered_q    <= buffered_d;
            discard_q     <= discard_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            oq_wr_q       <= oq_wr_d;
            oq_rd_q       <= oq_rd_d;
            tag_q         <= tag_d;
            oq_q          <= oq_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((imem_req_valid && !imem_req_ready) || (credits_used_c == credit_t'(DEPTH))) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_stall_cnt = stall_cnt_q;
`endif

    // A response with nothing in flight is a memory-side protocol violation.
    rsp_without_req: assert property (@(posedge clk) disable iff (!reset_n)
        imem_rsp_valid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_fetch_if2.sv
`timescale 1ns/1ps
// Self-checking bench for fetch_if2: in-order memory model with latency, IF1 PC register, and a program-order scoreboard.
module tb_fetch_if2;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] current_pc_if1, next_pc_if1, redirect_pc, imem_req_addr, imem_rsp_data, if2_pc, if2_inst;
    logic        pc_en, redirect_valid, imem_req_valid, imem_req_ready, imem_rsp_valid, imem_rsp_err;
    logic        if2_valid, id_ready, if2_fault;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_stall_cnt;
`endif

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    fetch_if2 dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .current_pc_if1 (current_pc_if1),
        .next_pc_if1    (next_pc_if1),
        .pc_en          (pc_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .if2_valid      (if2_valid),
        .id_ready       (id_ready),
        .if2_pc         (if2_pc),
        .if2_inst       (if2_inst),
        .if2_fault      (if2_fault)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_stall_cnt(fetch_stall_cnt)
`endif
    );

    // IF1 PC register that the stage drives
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) current_pc_if1 <= RESET_PC;
        else if (pc_en) current_pc_if1 <= next_pc_if1;
    end

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[31:16]} ^ 32'h5A3C_0F96;
    endfunction

    function automatic logic err_of(input logic [31:0] pc);
        return pc[6:2] == 5'd2;
    endfunction

    // stimulus knobs
    logic        rdy_drv, idr_drv, redir_drv;
    logic [31:0] redir_pc_drv;
    int          lat;
    int          cyc;

    // memory model: accepted requests with their response cycle, in order
    logic [31:0] mq_addr[$];
    int          mq_due[$];

    // per-cycle observations
    logic        o_req_valid, o_accept, o_pc_en, o_if2_valid, o_if2_fault, o_hs, o_rsp;
    logic [31:0] o_req_addr, o_next_pc, o_if2_pc, o_if2_inst, o_cur_pc;

    // scoreboard: next PC decode should receive in program order
    logic [31:0] exp_pc;

    task automatic cycle();
        @(negedge clk);
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(mq_addr[0]);
            imem_rsp_err   = err_of(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
            imem_rsp_err   = 1'b0;
        end
        imem_req_ready = rdy_drv;
        id_ready       = idr_drv;
        redirect_valid = redir_drv;
        redirect_pc    = redir_pc_drv;
        #1;
        o_req_valid = imem_req_valid;
        o_req_addr  = imem_req_addr;
        o_pc_en     = pc_en;
        o_next_pc   = next_pc_if1;
        o_if2_valid = if2_valid;
        o_if2_pc    = if2_pc;
        o_if2_inst  = if2_inst;
        o_if2_fault = if2_fault;
        o_cur_pc    = current_pc_if1;
        o_rsp       = imem_rsp_valid;
        o_hs        = if2_valid && id_ready;
        o_accept    = imem_req_valid && imem_req_ready;
        if (o_accept) begin
            int due;
            due = cyc + lat;
            if (mq_due.size() > 0 && due <= mq_due[$]) due = mq_due[$] + 1;
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(due);
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic apply_reset();
        reset_n        = 1'b0;
        rdy_drv        = 1'b0;
        idr_drv        = 1'b0;
        redir_drv      = 1'b0;
        redir_pc_drv   = 32'h0;
        lat            = 1;
        imem_req_ready = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        cyc    = 0;
        exp_pc = RESET_PC;
    endtask

    task automatic test_reset();
        apply_reset();
        cycle();
        nchk++; if (o_if2_valid !== 1'b0) begin nerr++; $display("FAIL reset_if2_valid: got %b exp 0", o_if2_valid); end
        nchk++; if (o_if2_pc !== 32'h0) begin nerr++; $display("FAIL reset_if2_pc: got %h exp 0", o_if2_pc); end
        nchk++; if (o_if2_inst !== 32'h0) begin nerr++; $display("FAIL reset_if2_inst: got %h exp 0", o_if2_inst); end
        nchk++; if (o_if2_fault !== 1'b0) begin nerr++; $display("FAIL reset_if2_fault: got %b exp 0", o_if2_fault); end
        nchk++; if (o_req_valid !== 1'b1) begin nerr++; $display("FAIL reset_req_valid: got %b exp 1", o_req_valid); end
        nchk++; if (o_req_addr !== RESET_PC) begin nerr++; $display("FAIL reset_req_addr: got %h exp %h", o_req_addr, RESET_PC); end
        nchk++; if (o_pc_en !== 1'b0) begin nerr++; $display("FAIL reset_pc_en_noready: got %b exp 0", o_pc_en); end
        nchk++; if (o_next_pc !== RESET_PC + 32'd4) begin nerr++; $display("FAIL reset_next_pc: got %h exp %h", o_next_pc, RESET_PC + 32'd4); end
    endtask

    task automatic test_fetch();
        logic [31:0] exp;
        apply_reset();
        rdy_drv = 1'b1; idr_drv = 1'b1; lat = 1;
        for (int c = 0; c < 10; c++) begin
            cycle();
            exp = RESET_PC + 32'(4 * c);
            nchk++; if (o_accept !== 1'b1 || o_req_addr !== exp) begin
                nerr++; $display("FAIL fetch_req c=%0d: got acc=%b addr=%h exp acc=1 addr=%h", c, o_accept, o_req_addr, exp);
            end
            if (c >= 2) begin
                exp = RESET_PC + 32'(4 * (c - 2));
                nchk++; if (o_if2_valid !== 1'b1 || o_if2_pc !== exp || o_if2_inst !== inst_of(exp)) begin
                    nerr++; $display("FAIL fetch_if2 c=%0d: got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h",
                                     c, o_if2_valid, o_if2_pc, o_if2_inst, exp, inst_of(exp));
                end
            end else begin
                nchk++; if (o_if2_valid !== 1'b0) begin nerr++; $display("FAIL fetch_early_valid c=%0d: got %b exp 0", c, o_if2_valid); end
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        rdy_drv = 1'b1; idr_drv = 1'b0; lat = 1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            if (c < 2) begin
                nchk++; if (o_accept !== 1'b1 || o_req_addr !== RESET_PC + 32'(4 * c)) begin
                    nerr++; $display("FAIL bp_fill c=%0d: got acc=%b addr=%h exp acc=1 addr=%h", c, o_accept, o_req_addr, RESET_PC + 32'(4 * c));
                end
            end else begin
                nchk++; if (o_req_valid !== 1'b0 || o_pc_en !== 1'b0 || o_req_addr !== RESET_PC + 32'd8) begin
                    nerr++; $display("FAIL bp_hold c=%0d: got rv=%b en=%b addr=%h exp rv=0 en=0 addr=%h", c, o_req_valid, o_pc_en, o_req_addr, RESET_PC + 32'd8);
                end
                nchk++; if (o_if2_valid !== 1'b1 || o_if2_pc !== RESET_PC) begin
                    nerr++; $display("FAIL bp_head c=%0d: got v=%b pc=%h exp v=1 pc=%h", c, o_if2_valid, o_if2_pc, RESET_PC);
                end
            end
        end
        idr_drv = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            nchk++; if (o_hs !== 1'b1 || o_if2_pc !== RESET_PC + 32'(4 * c)) begin
                nerr++; $display("FAIL bp_drain k=%0d: got hs=%b pc=%h exp hs=1 pc=%h", c, o_hs, o_if2_pc, RESET_PC + 32'(4 * c));
            end
        end
    endtask

    task automatic test_redirect();
        int n;
        apply_reset();
        rdy_drv = 1'b1; idr_drv = 1'b1; lat = 3;
        cycle(); cycle();
        nchk++; if (mq_addr.size() != 2) begin nerr++; $display("FAIL redir_setup: got outstanding=%0d exp 2", mq_addr.size()); end
        redir_drv = 1'b1; redir_pc_drv = 32'h8000_0100;
        cycle();
        nchk++; if (o_req_valid !== 1'b0 || o_pc_en !== 1'b1 || o_next_pc !== 32'h8000_0100) begin
            nerr++; $display("FAIL redir_cycle: got rv=%b en=%b npc=%h exp rv=0 en=1 npc=80000100", o_req_valid, o_pc_en, o_next_pc);
        end
        redir_drv = 1'b0; exp_pc = 32'h8000_0100;
        cycle();
        nchk++; if (o_if2_valid !== 1'b0) begin nerr++; $display("FAIL redir_t1_valid: got %b exp 0", o_if2_valid); end
        n = 0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (o_hs) begin
                nchk++; if (o_if2_pc !== exp_pc || o_if2_inst !== inst_of(exp_pc)) begin
                    nerr++; $display("FAIL redir_stream: got pc=%h inst=%h exp pc=%h inst=%h", o_if2_pc, o_if2_inst, exp_pc, inst_of(exp_pc));
                end
                exp_pc = exp_pc + 32'd4; n++;
            end
        end
        nchk++; if (n < 3) begin nerr++; $display("FAIL redir_progress: got %0d instructions exp >=3", n); end
    endtask

    task automatic test_collision();
        int n;
        apply_reset();
        rdy_drv = 1'b1; idr_drv = 1'b1; lat = 1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            if (o_hs) exp_pc = exp_pc + 32'd4;
        end
        redir_drv = 1'b1; redir_pc_drv = 32'h8000_0200;
        cycle();
        nchk++; if (o_hs !== 1'b1 || o_if2_pc !== RESET_PC + 32'd4 || o_rsp !== 1'b1) begin
            nerr++; $display("FAIL coll_cycle: got hs=%b pc=%h rsp=%b exp hs=1 pc=%h rsp=1", o_hs, o_if2_pc, o_rsp, RESET_PC + 32'd4);
        end
        redir_drv = 1'b0; exp_pc = 32'h8000_0200;
        cycle();
        nchk++; if (o_if2_valid !== 1'b0) begin nerr++; $display("FAIL coll_empty: got %b exp 0", o_if2_valid); end
        n = 0;
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (o_hs) begin
                nchk++; if (o_if2_pc !== exp_pc) begin nerr++; $display("FAIL coll_stream: got %h exp %h", o_if2_pc, exp_pc); end
                exp_pc = exp_pc + 32'd4; n++;
            end
        end
        nchk++; if (n < 4) begin nerr++; $display("FAIL coll_progress: got %0d instructions exp >=4", n); end
    endtask

    task automatic test_error_wrap();
        logic seen_fault, seen_wrap;
        apply_reset();
        rdy_drv = 1'b1; idr_drv = 1'b1; lat = 1;
        seen_fault = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (o_hs) begin
                nchk++; if (o_if2_pc !== exp_pc || o_if2_fault !== err_of(exp_pc)) begin
                    nerr++; $display("FAIL err_stream: got pc=%h f=%b exp pc=%h f=%b", o_if2_pc, o_if2_fault, exp_pc, err_of(exp_pc));
                end
                if (exp_pc == RESET_PC + 32'd8) begin
                    seen_fault = 1'b1;
                    nchk++; if (o_if2_fault !== 1'b1) begin nerr++; $display("FAIL err_fault_08: got %b exp 1", o_if2_fault); end
                end
                exp_pc = exp_pc + 32'd4;
            end
        end
        nchk++; if (!seen_fault) begin nerr++; $display("FAIL err_reached: got none exp pc 80000008 delivered"); end
        redir_drv = 1'b1; redir_pc_drv = 32'hFFFF_FFFC;
        cycle();
        redir_drv = 1'b0; exp_pc = 32'hFFFF_FFFC;
        cycle();
        nchk++; if (o_accept !== 1'b1 || o_req_addr !== 32'hFFFF_FFFC || o_next_pc !== 32'h0) begin
            nerr++; $display("FAIL wrap_req: got acc=%b addr=%h npc=%h exp acc=1 addr=fffffffc npc=0", o_accept, o_req_addr, o_next_pc);
        end
        cycle();
        nchk++; if (o_req_addr !== 32'h0) begin nerr++; $display("FAIL wrap_addr: got %h exp 0", o_req_addr); end
        seen_wrap = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (o_hs) begin
                nchk++; if (o_if2_pc !== exp_pc) begin nerr++; $display("FAIL wrap_stream: got %h exp %h", o_if2_pc, exp_pc); end
                if (exp_pc == 32'h0) seen_wrap = 1'b1;
                exp_pc = exp_pc + 32'd4;
            end
        end
        nchk++; if (!seen_wrap) begin nerr++; $display("FAIL wrap_reached: got none exp pc 00000000 delivered"); end
    endtask

    task automatic test_random();
        int          n;
        logic        prev_redir;
        logic [31:0] r;
        apply_reset();
        n = 0; prev_redir = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rdy_drv   = ($urandom_range(0, 3) != 0);
            idr_drv   = ($urandom_range(0, 3) != 0);
            redir_drv = ($urandom_range(0, 29) == 0);
            r = $urandom();
            redir_pc_drv = {r[31:2], 2'b00};
            lat = $urandom_range(1, 4);
            cycle();
            if (prev_redir) begin
                nchk++; if (o_if2_valid !== 1'b0) begin nerr++; $display("FAIL rnd_post_redir c=%0d: got valid=%b exp 0", c, o_if2_valid); end
            end
            nchk++; if (o_req_addr !== o_cur_pc) begin nerr++; $display("FAIL rnd_addr c=%0d: got %h exp %h", c, o_req_addr, o_cur_pc); end
            if (redir_drv) begin
                nchk++; if (o_pc_en !== 1'b1 || o_req_valid !== 1'b0 || o_next_pc !== redir_pc_drv) begin
                    nerr++; $display("FAIL rnd_redir c=%0d: got en=%b rv=%b npc=%h exp en=1 rv=0 npc=%h", c, o_pc_en, o_req_valid, o_next_pc, redir_pc_drv);
                end
            end else begin
                nchk++; if (o_pc_en !== o_accept || o_next_pc !== o_cur_pc + 32'd4) begin
                    nerr++; $display("FAIL rnd_pc c=%0d: got en=%b npc=%h exp en=%b npc=%h", c, o_pc_en, o_next_pc, o_accept, o_cur_pc + 32'd4);
                end
            end
            if (o_hs) begin
                nchk++; if (o_if2_pc !== exp_pc || o_if2_inst !== inst_of(exp_pc) || o_if2_fault !== err_of(exp_pc)) begin
                    nerr++; $display("FAIL rnd_stream c=%0d: got pc=%h inst=%h f=%b exp pc=%h inst=%h f=%b",
                                     c, o_if2_pc, o_if2_inst, o_if2_fault, exp_pc, inst_of(exp_pc), err_of(exp_pc));
                end
                exp_pc = exp_pc + 32'd4; n++;
            end
            if (redir_drv) exp_pc = redir_pc_drv;
            prev_redir = redir_drv;
        end
        nchk++; if (n < 300) begin nerr++; $display("FAIL rnd_progress: got %0d instructions exp >=300", n); end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        apply_reset();
        nchk++; if (fetch_stall_cnt !== 32'd0) begin nerr++; $display("FAIL perf_reset: got %0d exp 0", fetch_stall_cnt); end
        rdy_drv = 1'b0; idr_drv = 1'b1;
        repeat (7) cycle();
        #1;
        nchk++; if (fetch_stall_cnt !== 32'd7) begin nerr++; $display("FAIL perf_stall: got %0d exp 7", fetch_stall_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_backpressure();
        test_redirect();
        test_collision();
        test_error_wrap();
        test_random();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", nerr, nchk);
        $fatal(1);
    end

endmodule
